// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 bank arbiter with zero-fill.
// Contents:
//   state_e          bank controller state (fill in progress / normal service)
//   TCDM_BE_WIDTH    byte-enable width of a TCDM port (one enable per data byte)
//   DIFT_TAG_WIDTH   tag bits carried above the 32 data bits of a word
//   TCDM_ADDR_WIDTH  byte-address width of a TCDM port
package l2_arb_pkg;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int unsigned TCDM_BE_WIDTH   = 4;
  localparam int unsigned DIFT_TAG_WIDTH  = 4;
  localparam int unsigned TCDM_ADDR_WIDTH = 32;

  // Index of the requester that follows idx in a ring of nb entries.
  function automatic int unsigned ring_next(input int unsigned idx, input int unsigned nb);
    int unsigned nxt;
    if (idx >= (nb - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/l2_bank_arbiter_init_if.sv
// TCDM-style request/response bundle for NB_REQ requesters sharing one L2 bank.
// Signals (per requester, packed by requester index):
//   req      request
//   add      byte address
//   wen      1 = read, 0 = write
//   be       byte enables, active-high
//   wdata    write data (data + tag)
//   gnt      grant, same cycle as req
//   r_valid  response valid, cycle after grant
//   r_rdata  read data
// Modports: master = requester side, slave = bank arbiter side.
interface l2_bank_arbiter_init_if
  import l2_arb_pkg::*;
#(
  parameter int unsigned NB_REQ     = 4,
  parameter int unsigned DATA_WIDTH = 36
) ();

  logic [NB_REQ-1:0]                           req;
  logic [NB_REQ-1:0][TCDM_ADDR_WIDTH-1:0]      add;
  logic [NB_REQ-1:0]                           wen;
  logic [NB_REQ-1:0][TCDM_BE_WIDTH-1:0]        be;
  logic [NB_REQ-1:0][DATA_WIDTH-1:0]           wdata;
  logic [NB_REQ-1:0]                           gnt;
  logic [NB_REQ-1:0]                           r_valid;
  logic [NB_REQ-1:0][DATA_WIDTH-1:0]           r_rdata;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_rdata
  );

endinterface

// File: rtl/l2_rr_arbiter.sv
// Combinational round-robin pick among NB_REQ requests.
// Ports:
//   req_i    in   NB_REQ   request vector
//   ptr_i    in   IDX_W    highest-priority requester this cycle
//   gnt_o    out  NB_REQ   one-hot winner (all zero when nothing requested)
//   idx_o    out  IDX_W    winner index (0 when nothing requested)
//   valid_o  out  1        a winner exists
module l2_rr_arbiter #(
  parameter int unsigned NB_REQ = 4,
  parameter int unsigned IDX_W  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;

  // Scan ptr, ptr+1, ... (mod NB_REQ) and take the first active request.
  always_comb begin
    gnt_o   = {NB_REQ{1'b0}};
    idx_o   = {IDX_W{1'b0}};
    valid_o = 1'b0;
    sum_s   = {(IDX_W+1){1'b0}};
    cand_s  = {IDX_W{1'b0}};
    for (int k = 0; k < int'(NB_REQ); k++) begin
      sum_s  = {1'b0, ptr_i} + (IDX_W+1)'(k);
      sum_s  = (sum_s >= (IDX_W+1)'(NB_REQ)) ? (sum_s - (IDX_W+1)'(NB_REQ)) : sum_s;
      cand_s = sum_s[IDX_W-1:0];
      if (!valid_o && req_i[cand_s]) begin
        valid_o        = 1'b1;
        idx_o          = cand_s;
        gnt_o[cand_s]  = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/l2_bank_arbiter_init.sv
// Shares one single-port L2 SRAM bank among NB_REQ TCDM requesters with round-robin
// arbitration and a fixed one-cycle response, and zero-fills the whole bank after reset
// (when INIT_ON_RESET) or on an init_req_i pulse so data and tag bits start clean.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   init_req_i      pulse in normal service: start a zero-fill
//   init_done_o     high once a fill has completed, cleared when a fill starts
//   tcdm            requester bundle (slave side)
//   mem_cen_o       SRAM chip enable, active-low
//   mem_wen_o       SRAM write enable, 1 = read
//   mem_ben_o       SRAM byte enables, active-low
//   mem_a_o         SRAM word address
//   mem_d_o         SRAM write data
//   mem_q_i         SRAM read data, one cycle after the access
module l2_bank_arbiter_init
  import l2_arb_pkg::*;
#(
  parameter int unsigned NB_REQ        = 4,
  parameter int unsigned ADDR_WIDTH    = 13,
  parameter int unsigned DATA_WIDTH    = 36,
  parameter logic [31:0] BASE_ADDR     = 32'h1C00_0000,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     init_req_i,
  output logic                     init_done_o,
  l2_bank_arbiter_init_if.slave    tcdm,
  output logic                     mem_cen_o,
  output logic                     mem_wen_o,
  output logic [TCDM_BE_WIDTH-1:0] mem_ben_o,
  output logic [ADDR_WIDTH-1:0]    mem_a_o,
  output logic [DATA_WIDTH-1:0]    mem_d_o,
  input  logic [DATA_WIDTH-1:0]    mem_q_i
);

  localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam state_e RESET_STATE = INIT_ON_RESET ? S_INIT : S_RUN;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

  state_e                   state_r, state_s;
  logic [ADDR_WIDTH-1:0]    init_cnt_r, init_cnt_s;
  logic                     init_done_r, init_done_s;
  logic [IDX_W-1:0]         rr_ptr_r, rr_ptr_s;
  logic                     resp_valid_r;
  logic [IDX_W-1:0]         resp_idx_r;
  logic [NB_REQ-1:0]        r_valid_s;

  logic [NB_REQ-1:0]        arb_gnt_s;
  logic [IDX_W-1:0]         arb_idx_s;
  logic                     arb_valid_s;
  logic                     grant_s;

  logic                     mem_cen_s;
  logic                     mem_wen_s;
  logic [TCDM_BE_WIDTH-1:0] mem_ben_s;
  logic [ADDR_WIDTH-1:0]    mem_a_s;
  logic [DATA_WIDTH-1:0]    mem_d_s;

  l2_rr_arbiter #(
    .NB_REQ (NB_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req_i   (tcdm.req),
    .ptr_i   (rr_ptr_r),
    .gnt_o   (arb_gnt_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

  // Requests are only served in normal operation; the fill owns the bank otherwise.
  assign grant_s = (state_r == S_RUN) && arb_valid_s;

  // State, fill counter, pointer and response tracking registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= RESET_STATE;
      init_cnt_r   <= {ADDR_WIDTH{1'b0}};
      init_done_r  <= 1'b0;
      rr_ptr_r     <= {IDX_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r      <= state_s;
      init_cnt_r   <= init_cnt_s;
      init_done_r  <= init_done_s;
      rr_ptr_r     <= rr_ptr_s;
      resp_valid_r <= grant_s;
      resp_idx_r   <= grant_s ? arb_idx_s : resp_idx_r;
    end
  end

  // Next state, fill address sequencing and init_done bookkeeping.
  always_comb begin
    state_s     = state_r;
    init_cnt_s  = init_cnt_r;
    init_done_s = init_done_r;
    case (state_r)
      S_INIT: begin
        if (init_cnt_r == CNT_LAST) begin
          state_s     = S_RUN;
          init_done_s = 1'b1;
          init_cnt_s  = {ADDR_WIDTH{1'b0}};
        end else begin
          init_cnt_s  = init_cnt_r + ADDR_WIDTH'(1'b1);
        end
      end
      S_RUN: begin
        // A grant issued in this same cycle still completes; only the next cycle fills.
        if (init_req_i) begin
          state_s     = S_INIT;
          init_done_s = 1'b0;
        end else begin
          state_s     = S_RUN;
        end
      end
      default: begin
        state_s = RESET_STATE;
      end
    endcase
  end

  // Round-robin pointer moves just past the winner; idle cycles leave it alone.
  always_comb begin
    if (grant_s) begin
      rr_ptr_s = IDX_W'(ring_next(32'(arb_idx_s), NB_REQ));
    end else begin
      rr_ptr_s = rr_ptr_r;
    end
  end

  // SRAM port: zero-fill write during INIT, granted requester's access during RUN.
  always_comb begin
    mem_cen_s = 1'b1;
    mem_wen_s = 1'b0;
    mem_ben_s = {TCDM_BE_WIDTH{1'b0}};
    mem_a_s   = {ADDR_WIDTH{1'b0}};
    mem_d_s   = {DATA_WIDTH{1'b0}};
    case (state_r)
      S_INIT: begin
        mem_cen_s = 1'b0;
        mem_a_s   = init_cnt_r;
      end
      S_RUN: begin
        if (arb_valid_s) begin
          mem_cen_s = 1'b0;
          mem_wen_s = tcdm.wen[arb_idx_s];
          mem_ben_s = ~tcdm.be[arb_idx_s];
          mem_d_s   = tcdm.wdata[arb_idx_s];
          // Modulo 32-bit subtract: addresses outside the bank simply wrap into it.
          mem_a_s   = ADDR_WIDTH'((tcdm.add[arb_idx_s] - BASE_ADDR) >> 2'd2);
        end else begin
          mem_cen_s = 1'b1;
        end
      end
      default: begin
        mem_cen_s = 1'b1;
      end
    endcase
  end

  // One-hot response valid decoded from the registered winner.
  always_comb begin
    r_valid_s = {NB_REQ{1'b0}};
    if (resp_valid_r) begin
      r_valid_s[resp_idx_r] = 1'b1;
    end else begin
      r_valid_s = {NB_REQ{1'b0}};
    end
  end

  assign tcdm.gnt     = grant_s ? arb_gnt_s : {NB_REQ{1'b0}};
  assign tcdm.r_valid = r_valid_s;
  assign tcdm.r_rdata = {NB_REQ{mem_q_i}};
  assign init_done_o  = init_done_r;

  assign mem_cen_o = mem_cen_s;
  assign mem_wen_o = mem_wen_s;
  assign mem_ben_o = mem_ben_s;
  assign mem_a_o   = mem_a_s;
  assign mem_d_o   = mem_d_s;

endmodule

// File: tb/tb_l2_bank_arbiter_init.sv
// Self-checking bench for l2_bank_arbiter_init (4 requesters, 16-word bank).
// A behavioural SRAM stub answers the memory port; a reference model tracks the
// expected mode, round-robin order, bank contents and pending responses.
module tb_l2_bank_arbiter_init;

  localparam int          NB  = 4;
  localparam int          AW  = 4;
  localparam int          DW  = 36;
  localparam int          NW  = 16;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic          clk;
  logic          rst_n;
  logic          init_req;
  logic          init_done;
  logic          mem_cen;
  logic          mem_wen;
  logic [3:0]    mem_ben;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  l2_bank_arbiter_init_if #(.NB_REQ(NB), .DATA_WIDTH(DW)) bus ();

  l2_bank_arbiter_init #(
    .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .init_done_o(init_done),
    .tcdm(bus),
    .mem_cen_o(mem_cen), .mem_wen_o(mem_wen), .mem_ben_o(mem_ben),
    .mem_a_o(mem_a), .mem_d_o(mem_d), .mem_q_i(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM stub: active-low enables, one-cycle read latency, byte k covers data byte k and tag bit k.
  logic [DW-1:0] sram [NW];
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (mem_wen) begin
        mem_q <= sram[mem_a];
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!mem_ben[k]) begin
            sram[mem_a][8*k +: 8] <= mem_d[8*k +: 8];
            sram[mem_a][32+k]     <= mem_d[32+k];
          end
        end
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  bit            m_fill;
  int            m_cnt;
  int            m_ptr;
  bit            m_done;
  int            m_rv;
  bit            m_rv_read;
  logic [DW-1:0] m_rv_data;
  logic [DW-1:0] ref_mem [NW];

  task automatic set_idle();
    bus.req = '0;
    for (int i = 0; i < NB; i++) begin
      bus.add[i] = BASE; bus.wen[i] = 1'b1; bus.be[i] = 4'h0; bus.wdata[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input bit wen, input logic [31:0] add,
                         input logic [3:0] be, input logic [DW-1:0] d);
    bus.req[i] = 1'b1; bus.wen[i] = wen; bus.add[i] = add; bus.be[i] = be; bus.wdata[i] = d;
  endtask

  task automatic set_rand();
    for (int i = 0; i < NB; i++) begin
      bus.req[i]   = ($urandom_range(0, 2) != 0);
      bus.wen[i]   = $urandom_range(0, 1) != 0;
      bus.be[i]    = 4'($urandom_range(0, 15));
      bus.wdata[i] = {4'($urandom_range(0, 15)), 32'($urandom)};
      if ($urandom_range(0, 9) == 0) bus.add[i] = 32'($urandom);
      else bus.add[i] = BASE + 32'($urandom_range(0, 127));
    end
  endtask

  // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    int            w;
    int            a;
    logic [31:0]   off;
    logic [3:0]    eben;
    logic [NB-1:0] egnt;
    @(negedge clk);
    check_val("init_done", init_done, m_done);
    egnt = (m_rv >= 0) ? NB'(1 << m_rv) : '0;
    check_val("r_valid", bus.r_valid, egnt);
    if (m_rv >= 0 && m_rv_read) check_val("r_rdata", bus.r_rdata[m_rv], m_rv_data);
    w = -1;
    a = 0;
    if (!m_fill) begin
      for (int k = 0; k < NB; k++) begin
        int c;
        c = (m_ptr + k) % NB;
        if (w < 0 && bus.req[c]) w = c;
      end
    end
    if (m_fill) begin
      check_val("fill_gnt", bus.gnt, 0);
      check_val("fill_cen", mem_cen, 0);
      check_val("fill_wen", mem_wen, 0);
      check_val("fill_ben", mem_ben, 0);
      check_val("fill_addr", mem_a, m_cnt);
      check_val("fill_data", mem_d, 0);
    end else if (w >= 0) begin
      off  = bus.add[w] - BASE;
      a    = int'(off >> 2) % NW;
      eben = ~bus.be[w];
      egnt = NB'(1 << w);
      check_val("gnt", bus.gnt, egnt);
      check_val("cen", mem_cen, 0);
      check_val("wen", mem_wen, bus.wen[w]);
      check_val("ben", mem_ben, eben);
      check_val("addr", mem_a, a);
      check_val("wdata", mem_d, bus.wdata[w]);
    end else begin
      check_val("idle_gnt", bus.gnt, 0);
      check_val("idle_cen", mem_cen, 1);
    end
    @(posedge clk);
    if (m_fill) begin
      ref_mem[m_cnt] = '0;
      m_rv = -1;
      if (m_cnt == NW - 1) begin
        m_fill = 0; m_done = 1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (w >= 0) begin
        m_rv      = w;
        m_rv_read = bus.wen[w];
        if (bus.wen[w]) begin
          m_rv_data = ref_mem[a];
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (bus.be[w][k]) begin
              ref_mem[a][8*k +: 8] = bus.wdata[w][8*k +: 8];
              ref_mem[a][32+k]     = bus.wdata[w][32+k];
            end
          end
        end
        m_ptr = (w + 1) % NB;
      end else begin
        m_rv = -1;
      end
      if (init_req) begin
        m_fill = 1; m_done = 0;
      end
    end
    #1;
  endtask

  // Reset applied away from the clock edge; released just after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    init_req = 1'b0;
    m_fill = 1; m_cnt = 0; m_ptr = 0; m_done = 0; m_rv = -1; m_rv_read = 0;
    repeat (2) @(negedge clk);
    check_val("rst_init_done", init_done, 0);
    check_val("rst_r_valid", bus.r_valid, 0);
    check_val("rst_gnt", bus.gnt, 0);
    check_val("rst_addr", mem_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    init_req = 1'b0;
    set_idle();
    #2;
    do_reset();

    // 1: power-on fill with requests pending, done visible on cycle 17
    for (int c = 0; c < NW; c++) begin set_rand(); tick(); end
    set_idle();
    tick();
    check_val("t1_done", init_done, 1);

    // 2: write then read back through requester 0
    set_req(0, 1'b0, BASE + 32'd8, 4'hF, 36'hA_DEADBEEF); tick();
    set_idle(); set_req(0, 1'b1, BASE + 32'd8, 4'hF, '0); tick();
    set_idle();
    check_val("t2_rdata", bus.r_rdata[0], 36'hA_DEADBEEF);
    tick();

    // 3: pointer back to 0, then all four requesting for 8 cycles
    set_req(3, 1'b1, BASE, 4'hF, '0); tick();
    set_idle();
    for (int c = 0; c < 4; c++) set_req(c, 1'b1, BASE + 32'(4 * c), 4'hF, '0);
    for (int c = 0; c < 8; c++) tick();
    set_idle(); tick();

    // 4: pointer at 2, requesters 1 and 3, be = 0101
    set_req(1, 1'b1, BASE, 4'hF, '0); tick();
    set_idle();
    set_req(1, 1'b0, BASE + 32'd20, 4'b0101, 36'h5_12345678);
    set_req(3, 1'b0, BASE + 32'd24, 4'b0101, 36'h3_89ABCDEF);
    tick(); tick();
    set_idle(); tick();

    // 5: init request while requester 2 is granted; data cleared afterwards
    set_req(2, 1'b1, BASE + 32'd8, 4'hF, '0);
    init_req = 1'b1; tick();
    init_req = 1'b0;
    for (int c = 0; c < NW; c++) begin set_rand(); init_req = 1'b1; tick(); end
    init_req = 1'b0;
    set_idle(); set_req(0, 1'b1, BASE + 32'd8, 4'hF, '0); tick();
    set_idle();
    check_val("t5_cleared", bus.r_rdata[0], 0);
    tick();

    // random traffic with occasional fills
    for (int c = 0; c < 400; c++) begin
      set_rand();
      init_req = ($urandom_range(0, 39) == 0);
      tick();
    end
    init_req = 1'b0;

    // 6: reset in the middle of a fill, then a complete fresh fill
    set_idle();
    while (m_fill) tick();
    init_req = 1'b1; tick();
    init_req = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    check_val("t6_cnt", m_cnt, 7);
    do_reset();
    for (int c = 0; c < NW + 4; c++) begin set_rand(); tick(); end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
